clause_sched_ctrl: RTL
======================

Name: clause_sched_ctrl

Overview:
- Top-level sequencer for the convolutional clause-evaluation array in one inference pass.
- Walks every (class, clause) pair and drives the clause address and the clause_act enable to the array.
- For each clause, waits for the patch scan to finish, then samples the OR-reduced clause output.
- Accumulates the signed class vote (even clause = positive polarity, odd = negative) and reports the argmax class with its sum.

Parameters:
- CLAUSEN, 10, maximum clauses per class (clause address space per class).
- CLASSN, 5, number of classes.
- BRAM_LAT, 2, cycles from a clause_no/class_no change until clause data is valid at the array (range 1..7).
- OP_LAT, 3, cycles from scan_done until clause_op is final (PE plus OR-chain pipeline, range 1..7).
- SUM_W, $clog2(CLAUSEN)+2, signed width of class sums.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset; synchronous, active-high.
- start, in, 1, one-cycle pulse that begins an inference; ignored unless in IDLE.
- clauses, in, $clog2(CLAUSEN)+1, runtime clauses per class; values above CLAUSEN are clamped to CLAUSEN.
- scan_done, in, 1, pulse from the patch-position generator when the last patch window has been issued.
- clause_op, in, 1, accumulated clause output from the array.
- class_no, out, $clog2(CLASSN), class address to the array.
- clause_no, out, $clog2(CLAUSEN)+1, clause address to the array.
- clause_act, out, 1, clause-evaluation enable; low clears the array's match pipeline.
- img_rst, out, 1, one-cycle pulse at the start of each inference.
- busy, out, 1, high from start acceptance until done.
- done, out, 1, one-cycle pulse when the result is valid.
- pred_class, out, $clog2(CLASSN), winning class; held until the next done.
- pred_sum, out, SUM_W signed, sum of the winning class; held until the next done.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters and accumulators 0.
- rst in any state forces IDLE on the next edge; no done pulse is produced for the aborted run.
- States:
  - IDLE: wait for start. On start: busy=1, img_rst=1 for that one cycle, class_no=0, clause_no=0, best_sum = most negative SUM_W value. If clauses==0 after clamping, go to FIN; otherwise go to SETTLE.
  - SETTLE: clause_act=0; count BRAM_LAT cycles, then go to RUN.
  - RUN: clause_act=1 until scan_done is seen. scan_done is ignored in every state except RUN.
  - DRAIN: clause_act stays 1 for OP_LAT cycles after the scan_done cycle. On the last DRAIN cycle clause_op is registered; go to ACCUM.
  - ACCUM: clause_act=0. acc += clause_op when clause_no[0]==0; acc -= clause_op when clause_no[0]==1. If clause_no == clauses-1, go to CLASS_END; otherwise clause_no++ and go to SETTLE.
  - CLASS_END: if acc > best_sum (strictly greater, so ties keep the lower class), update best_sum and best_class. acc=0. If class_no == CLASSN-1, go to FIN; otherwise class_no++, clause_no=0, go to SETTLE.
  - FIN: pred_class=best_class and pred_sum=best_sum (both 0 if clauses==0); done=1 for one cycle; busy=0; return to IDLE.
- Timing:
  - clause_act is deasserted for at least BRAM_LAT+1 cycles between consecutive clauses, so the array clears its match state.
  - Per-clause latency = BRAM_LAT + scan length + OP_LAT + 1 cycles.
  - CLASS_END adds 1 cycle per class; FIN adds 1 cycle per inference.
- Arithmetic:
  - acc and best_sum are SUM_W signed. The range ±CLAUSEN cannot overflow SUM_W.
  - clause_no and class_no never exceed their last legal index; no wrap is possible.
- Simultaneous events:
  - start in the same cycle as rst: rst wins.
  - start while busy: ignored.
  - scan_done in the first RUN cycle: accepted.

Optional Feature:
- Macro: CLAUSE_SCHED_SUM_OUT_EN.
- Defined:
  - Adds output class_sum (SUM_W, signed) and class_sum_valid (1 bit).
  - In each CLASS_END cycle, class_sum = the completed acc for class_no and class_sum_valid=1.
  - Otherwise class_sum_valid=0 and class_sum holds its last value; both reset to 0.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
1. Reset/idle: rst for 3 cycles, no start -> all outputs 0, clause_act stays 0 for 100 cycles.
2. Basic vote, CLASSN=2, clauses=4, scan_done 5 cycles into each RUN:
   - clause_op pattern class0 = 1,0,1,0 and class1 = 1,1,1,1.
   - Required: sums +2 and 0; done with pred_class=0, pred_sum=2.
   - Inference length matches the per-clause latency formula exactly.
3. Tie and negatives, CLASSN=3, clauses=2:
   - class0 clause_op = 0,1 (sum -1); class1 = 1,0 (sum +1); class2 = 1,0 (sum +1).
   - Required: pred_class=1, pred_sum=1 (lower class wins the tie).
4. clauses=0 -> done exactly 2 cycles after start; pred_class=0, pred_sum=0; clause_act never high.
5. Mid-run abort: assert rst during RUN of class1, clause2 -> IDLE next cycle; busy=0; no done. A fresh start then completes normally.
6. Ignored inputs:
   - start pulsed while busy -> no restart.
   - scan_done pulsed during SETTLE -> no effect on the sequence.
   - With CLAUSE_SCHED_SUM_OUT_EN defined: one class_sum_valid pulse per class, values match scenario 2 (2, then 0).

Source files
------------

// File: rtl/clause_sched_ctrl.sv
// clause_sched_ctrl: sequencer for the convolutional clause-evaluation array.
// Walks every (class, clause) pair for one inference. For each clause it lets
// the clause data settle, enables evaluation until the patch scan finishes,
// drains the output pipeline, then adds the clause output into a signed class
// vote. Even clauses vote positively and odd clauses vote negatively. At the
// end it reports the argmax class and that class's sum.
//
// Optional build macro: CLAUSE_SCHED_SUM_OUT_EN adds the class_sum and
// class_sum_valid outputs, which report each class vote as it completes.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start           one-cycle pulse; starts an inference when idle
//   clauses         runtime clauses per class (clamped to CLAUSEN)
//   scan_done       last patch window issued (honoured only in RUN)
//   clause_op       OR-reduced clause output from the array
//   class_no        class address to the array
//   clause_no       clause address to the array
//   clause_act      clause-evaluation enable (low clears match pipeline)
//   img_rst         one-cycle pulse at inference start
//   busy            inference in progress
//   done            one-cycle pulse, result valid
//   pred_class      winning class, held until next done
//   pred_sum        winning class sum, held until next done
//   class_sum       (optional) completed sum of the current class
//   class_sum_valid (optional) class_sum update strobe
`timescale 1ns/1ps
module clause_sched_ctrl #(
  parameter int unsigned CLAUSEN  = 10,
  parameter int unsigned CLASSN   = 5,
  parameter int unsigned BRAM_LAT = 2,
  parameter int unsigned OP_LAT   = 3,
  parameter int unsigned SUM_W    = $clog2(CLAUSEN) + 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(CLAUSEN):0]      clauses,
  input  logic                          scan_done,
  input  logic                          clause_op,
  output logic [$clog2(CLASSN)-1:0]     class_no,
  output logic [$clog2(CLAUSEN):0]      clause_no,
  output logic                          clause_act,
  output logic                          img_rst,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(CLASSN)-1:0]     pred_class,
`ifdef CLAUSE_SCHED_SUM_OUT_EN
  output logic signed [SUM_W-1:0]       class_sum,
  output logic                          class_sum_valid,
`endif
  output logic signed [SUM_W-1:0]       pred_sum
);

  localparam int unsigned CLA_W = $clog2(CLAUSEN) + 1;
  localparam int unsigned CLS_W = $clog2(CLASSN);
  localparam int unsigned CNT_W = 3;
  localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_RUN,
    S_DRAIN,
    S_ACCUM,
    S_CLASS_END,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [CLA_W-1:0]        clauses_q, clauses_d;
  logic [CLA_W-1:0]        clauses_clamp;
  logic [CLA_W-1:0]        clause_no_d;
  logic [CLS_W-1:0]        class_no_d;
  logic                    op_q, op_d;
  logic signed [SUM_W-1:0] op_ext;
  logic signed [SUM_W-1:0] acc, acc_d;
  logic signed [SUM_W-1:0] best_sum, best_sum_d;
  logic [CLS_W-1:0]        best_class, best_class_d;
  logic [CLS_W-1:0]        pred_class_d;
  logic signed [SUM_W-1:0] pred_sum_d;
  logic                    clause_act_d, img_rst_d, busy_d, done_d;
  logic                    last_clause, last_class;
  logic                    settle_end, drain_end;

  assign clauses_clamp = (clauses > CLA_W'(CLAUSEN)) ? CLA_W'(CLAUSEN) : clauses;
  assign last_clause   = (clause_no == clauses_q - CLA_W'(1));
  assign last_class    = (class_no == CLS_W'(CLASSN - 1));
  assign settle_end    = (cnt == CNT_W'(BRAM_LAT - 1));
  assign drain_end     = (cnt == CNT_W'(OP_LAT - 1));
  assign op_ext        = SUM_W'(op_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = (clauses_clamp == '0) ? S_FIN : S_SETTLE;
      S_SETTLE:    if (settle_end) state_nxt = S_RUN;
      S_RUN:       if (scan_done) state_nxt = S_DRAIN;
      S_DRAIN:     if (drain_end) state_nxt = S_ACCUM;
      S_ACCUM:     state_nxt = last_clause ? S_CLASS_END : S_SETTLE;
      S_CLASS_END: state_nxt = last_class ? S_FIN : S_SETTLE;
      S_FIN:       state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values; outputs are registered so they line up
  // with the state they describe (clause_act high exactly in RUN/DRAIN).
  always_comb begin
    cnt_d        = '0;
    clauses_d    = clauses_q;
    class_no_d   = class_no;
    clause_no_d  = clause_no;
    op_d         = op_q;
    acc_d        = acc;
    best_sum_d   = best_sum;
    best_class_d = best_class;
    pred_class_d = pred_class;
    pred_sum_d   = pred_sum;
    clause_act_d = (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
    busy_d       = (state_nxt != S_IDLE);
    img_rst_d    = 1'b0;
    done_d       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          img_rst_d    = 1'b1;
          clauses_d    = clauses_clamp;
          class_no_d   = '0;
          clause_no_d  = '0;
          acc_d        = '0;
          best_sum_d   = SUM_MIN;
          best_class_d = '0;
        end
      end
      S_SETTLE: begin
        if (!settle_end) cnt_d = cnt + CNT_W'(1);
      end
      S_DRAIN: begin
        if (drain_end) op_d = clause_op;
        else           cnt_d = cnt + CNT_W'(1);
      end
      S_ACCUM: begin
        acc_d = clause_no[0] ? (acc - op_ext) : (acc + op_ext);
        if (!last_clause) clause_no_d = clause_no + CLA_W'(1);
      end
      S_CLASS_END: begin
        // Strict compare: on a tie the earlier (lower) class is kept.
        if (acc > best_sum) begin
          best_sum_d   = acc;
          best_class_d = class_no;
        end
        acc_d = '0;
        if (!last_class) begin
          class_no_d  = class_no + CLS_W'(1);
          clause_no_d = '0;
        end
      end
      S_FIN: begin
        done_d = 1'b1;
        // With no clauses best_sum still holds the sentinel; report zero.
        if (clauses_q == '0) begin
          pred_class_d = '0;
          pred_sum_d   = '0;
        end else begin
          pred_class_d = best_class;
          pred_sum_d   = best_sum;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      clauses_q  <= '0;
      class_no   <= '0;
      clause_no  <= '0;
      op_q       <= 1'b0;
      acc        <= '0;
      best_sum   <= '0;
      best_class <= '0;
      pred_class <= '0;
      pred_sum   <= '0;
      clause_act <= 1'b0;
      busy       <= 1'b0;
      img_rst    <= 1'b0;
      done       <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      clauses_q  <= clauses_d;
      class_no   <= class_no_d;
      clause_no  <= clause_no_d;
      op_q       <= op_d;
      acc        <= acc_d;
      best_sum   <= best_sum_d;
      best_class <= best_class_d;
      pred_class <= pred_class_d;
      pred_sum   <= pred_sum_d;
      clause_act <= clause_act_d;
      busy       <= busy_d;
      img_rst    <= img_rst_d;
      done       <= done_d;
    end
  end

`ifdef CLAUSE_SCHED_SUM_OUT_EN
  // Per-class vote export: acc is the finished class sum in CLASS_END.
  always_ff @(posedge clk) begin
    if (rst) begin
      class_sum       <= '0;
      class_sum_valid <= 1'b0;
    end else begin
      class_sum_valid <= (state == S_CLASS_END);
      if (state == S_CLASS_END) class_sum <= acc;
    end
  end
`else
  // Per-class sums are not exported in this build.
`endif

endmodule
